encoder_8x3: RTL and testbench

- Registered 8-to-3 priority encoder.
- Converts an 8-bit request/one-hot vector `a` into the 3-bit index `y` of the highest-numbered asserted bit.
- Also reports `valid` (any bit set) and `multi` (more than one bit set).
- Sits behind request/status vectors wherever a compact binary index is needed; one clock cycle of latency.

---
 rtl/encoder_8x3.sv | 69 ++++++
 tb/tb_encoder_8x3.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8x3.sv
// ---------------------------------------------------------------------------
// encoder_8x3
// Registered 8-to-3 priority encoder with one cycle of latency. Reports the
// index of the highest-numbered set bit of the input vector together with an
// any-bit-set flag and a more-than-one-bit-set flag.
//
// Ports
//   clk    in   1  system clock, rising edge active
//   rst_n  in   1  asynchronous active-low reset, clears all outputs
//   en     in   1  capture enable; outputs load from `a` on the next edge
//   a      in   8  request vector; bit i set means index i is requested
//   y      out  3  registered index of the highest set bit of `a`
//   valid  out  1  registered; captured `a` had at least one bit set
//   multi  out  1  registered; captured `a` had two or more bits set
// ---------------------------------------------------------------------------
module encoder_8x3 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] a,
   output logic [2:0] y,
   output logic       valid,
   output logic       multi
);

   localparam int unsigned IN_W  = 8;
   localparam int unsigned OUT_W = 3;

   logic [OUT_W-1:0] w_y_next;
   logic             w_valid_next;
   logic             w_multi_next;

   logic [OUT_W-1:0] r_y;
   logic             r_valid;
   logic             r_multi;

   // Priority encode: ascending scan so the highest set bit is the last to win.
   always_comb begin
      w_y_next = '0;
      for (int i = 0; i < IN_W; i++) begin
         if (a[i]) begin
            w_y_next = OUT_W'(i);
         end
      end
   end

   assign w_valid_next = |a;

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign w_multi_next = |(a & (a - IN_W'(1)));

   // Output registers; hold when en is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y     <= '0;
         r_valid <= 1'b0;
         r_multi <= 1'b0;
      end else if (en) begin
         r_y     <= w_y_next;
         r_valid <= w_valid_next;
         r_multi <= w_multi_next;
      end
   end

   assign y     = r_y;
   assign valid = r_valid;
   assign multi = r_multi;

endmodule

// File: tb/tb_encoder_8x3.sv
// ---------------------------------------------------------------------------
// tb_encoder_8x3
// Self-checking bench for encoder_8x3: directed scenarios plus randomized
// vectors compared against a behavioural model (floor-log2 of the vector,
// nonzero test, population count).
// ---------------------------------------------------------------------------
module tb_encoder_8x3;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] a;
   logic [2:0] y;
   logic       valid;
   logic       multi;

   int n_tests;
   int n_fail;

   encoder_8x3 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a     (a),
      .y     (y),
      .valid (valid),
      .multi (multi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: index = floor(log2(v)), found by repeated halving.
   task automatic model(input logic [7:0] v, output logic [2:0] ey,
                        output logic ev, output logic em);
      int unsigned n;
      int unsigned idx;
      n   = int'(v);
      idx = 0;
      while (n > 1) begin
         n   = n / 2;
         idx = idx + 1;
      end
      ey = 3'(idx);
      ev = (v != 8'h00);
      em = ($countones(v) >= 2);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [2:0] ey;
      logic       ev, em;
      rst_n = 1'b0;
      en    = 1'b1;
      a     = 8'hFF;
      tick();
      n_tests++;
      if (y !== 3'b000 || valid !== 1'b0 || multi !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: got y=%b valid=%b multi=%b, want 000 0 0", y, valid, multi);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      model(8'hFF, ey, ev, em);
      n_tests++;
      if (y !== ey || valid !== ev || multi !== em || y !== 3'b111) begin
         n_fail++;
         $display("FAIL reset_release: got y=%b valid=%b multi=%b, want %b %b %b", y, valid, multi, ey, ev, em);
      end
      // Asynchronous pulse between edges must clear at once.
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (y !== 3'b000 || valid !== 1'b0 || multi !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: got y=%b valid=%b multi=%b, want 000 0 0", y, valid, multi);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_onehot_sweep();
      logic [7:0] vec;
      logic [2:0] ey;
      logic       ev, em;
      en = 1'b1;
      for (int i = -1; i < 8; i++) begin
         vec = (i < 0) ? 8'h00 : 8'(1 << i);
         a   = vec;
         model(vec, ey, ev, em);
         tick();
         n_tests++;
         if (y !== ey || valid !== ev || multi !== em) begin
            n_fail++;
            $display("FAIL onehot a=%b: got y=%b valid=%b multi=%b, want %b %b %b", vec, y, valid, multi, ey, ev, em);
         end
      end
   endtask

   task automatic test_priority();
      logic [7:0] vecs [3];
      logic [2:0] want_y [3];
      logic       want_m [3];
      vecs[0] = 8'b0010_0110; want_y[0] = 3'b101; want_m[0] = 1'b1;
      vecs[1] = 8'b0000_0001; want_y[1] = 3'b000; want_m[1] = 1'b0;
      vecs[2] = 8'b1000_0001; want_y[2] = 3'b111; want_m[2] = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a = vecs[i];
         tick();
         n_tests++;
         if (y !== want_y[i] || valid !== 1'b1 || multi !== want_m[i]) begin
            n_fail++;
            $display("FAIL priority a=%b: got y=%b valid=%b multi=%b, want %b 1 %b", vecs[i], y, valid, multi, want_y[i], want_m[i]);
         end
      end
   endtask

   task automatic test_enable_hold();
      en = 1'b1;
      a  = 8'b0001_0000;
      tick();
      n_tests++;
      if (y !== 3'b100 || valid !== 1'b1 || multi !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_capture: got y=%b valid=%b multi=%b, want 100 1 0", y, valid, multi);
      end
      en = 1'b0;
      a  = 8'b1000_0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (y !== 3'b100 || valid !== 1'b1 || multi !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_edge%0d: got y=%b valid=%b multi=%b, want 100 1 0", i, y, valid, multi);
         end
      end
      en = 1'b1;
      tick();
      n_tests++;
      if (y !== 3'b111 || valid !== 1'b1 || multi !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_resume: got y=%b valid=%b multi=%b, want 111 1 0", y, valid, multi);
      end
   endtask

   // Random vectors and random enable; reset is pulsed mid-stream.
   task automatic test_random();
      logic [7:0] vec;
      logic [2:0] ey, ny;
      logic       ev, em, nv, nm;
      // Expected state starts from whatever the previous test left.
      en = 1'b1;
      a  = 8'h5A;
      model(8'h5A, ey, ev, em);
      tick();
      for (int i = 0; i < 60; i++) begin
         vec = 8'($urandom);
         if (i % 4 == 0) vec = 8'(1 << $urandom_range(7, 0));
         a  = vec;
         en = ($urandom_range(3, 0) != 0);
         if (en) begin
            model(vec, ny, nv, nm);
            ey = ny; ev = nv; em = nm;
         end
         tick();
         n_tests++;
         if (y !== ey || valid !== ev || multi !== em) begin
            n_fail++;
            $display("FAIL random[%0d] a=%b en=%b: got y=%b valid=%b multi=%b, want %b %b %b", i, vec, en, y, valid, multi, ey, ev, em);
         end
         if (i == 30) begin
            // Clear between edges and hold reset across one edge with en=1.
            en = 1'b1;
            a  = 8'hC3;
            #2 rst_n = 1'b0;
            #1;
            n_tests++;
            if (y !== 3'b000 || valid !== 1'b0 || multi !== 1'b0) begin
               n_fail++;
               $display("FAIL random_rst_async: got y=%b valid=%b multi=%b, want 000 0 0", y, valid, multi);
            end
            tick();
            n_tests++;
            if (y !== 3'b000 || valid !== 1'b0 || multi !== 1'b0) begin
               n_fail++;
               $display("FAIL random_rst_edge: got y=%b valid=%b multi=%b, want 000 0 0", y, valid, multi);
            end
            @(negedge clk);
            rst_n = 1'b1;
            ey = 3'b000; ev = 1'b0; em = 1'b0;
            model(8'hC3, ny, nv, nm);
            tick();
            n_tests++;
            if (y !== ny || valid !== nv || multi !== nm) begin
               n_fail++;
               $display("FAIL random_rst_resume: got y=%b valid=%b multi=%b, want %b %b %b", y, valid, multi, ny, nv, nm);
            end
            ey = ny; ev = nv; em = nm;
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      en      = 1'b0;
      a       = 8'h00;
      #1;
      test_reset();
      test_onehot_sweep();
      test_priority();
      test_enable_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
